// File: rtl/loa_pkg.sv
// loa_pkg: shared widths, split point and result types for the lower-part-OR approximate subtractor.
package loa_pkg;
  localparam int LOA_WIDTH = 32;
  localparam int LOA_LOWER_BITS_DEFAULT = 8;
  localparam int LOA_SPLIT_BIT = 20;
  typedef logic [LOA_WIDTH:0] loa_result_t;
  typedef struct packed {
    logic [LOA_WIDTH-1:LOA_SPLIT_BIT] a_hi;
    logic [LOA_WIDTH-1:LOA_SPLIT_BIT] b_hi;
    logic [LOA_SPLIT_BIT-1:0] diff_lo;
    logic borrow;
  } loa_s1_t;
  function automatic loa_result_t loa_exact(input logic [LOA_WIDTH-1:0] a, input logic [LOA_WIDTH-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction
endpackage

// File: rtl/loa_pipe_reg.sv
// loa_pipe_reg: one valid/ready pipeline stage (data register plus valid flag).
module loa_pipe_reg #(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         out_ready_i
);
  logic         valid_q;
  logic [W-1:0] data_q;
  assign in_ready_o = ~valid_q | out_ready_i;
  assign valid_o = valid_q;
  assign data_o = data_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) data_q <= data_i;
    end
  end
endmodule

// File: rtl/loa_sub_pipe.sv
// loa_sub_pipe: two-stage approximate subtractor (OR-approximated low bits, exact upper bits).
// Optional error statistics against the exact difference: define LOA_SUB_ERRSTAT_EN.
module loa_sub_pipe
  import loa_pkg::*;
#(
  parameter int LOWER_BITS = LOA_LOWER_BITS_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [LOA_WIDTH-1:0] min_i,
  input  logic [LOA_WIDTH-1:0] sub_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [LOA_WIDTH:0]   result_o,
`ifdef LOA_SUB_ERRSTAT_EN
  output logic [15:0]          errcnt_o,
  input  logic                 errclr_i,
`endif
  output logic                 out_valid_o,
  input  logic                 out_ready_i
);
  localparam int SB = LOA_SPLIT_BIT;
  localparam int HW = LOA_WIDTH - SB;
`ifdef LOA_SUB_ERRSTAT_EN
  localparam int S1W = $bits(loa_s1_t) + 2 * LOA_WIDTH;
  localparam int S2W = LOA_WIDTH + 2;
`else
  localparam int S1W = $bits(loa_s1_t);
  localparam int S2W = LOA_WIDTH + 1;
`endif
  logic [SB-1:0]  lo_mask;
  logic           borrow_lo;
  logic [SB:0]    mid;
  loa_s1_t        s1_d;
  loa_s1_t        s1_q;
  logic [S1W-1:0] s1_in;
  logic [S1W-1:0] s1_data_q;
  logic           s1_valid;
  logic           s2_ready;
  logic [HW:0]    hi;
  loa_result_t    res_d;
  logic [S2W-1:0] s2_in;
  logic [S2W-1:0] s2_data_q;
  assign lo_mask = ~({SB{1'b1}} << LOWER_BITS);
  assign borrow_lo = ~min_i[LOWER_BITS-1] & sub_i[LOWER_BITS-1];
  // Low bits are masked to zero so the borrow out of bit SB-1 comes straight from the top of mid.
  assign mid = {1'b0, min_i[SB-1:0] & ~lo_mask} - {1'b0, sub_i[SB-1:0] & ~lo_mask}
             - ((SB+1)'(borrow_lo) << LOWER_BITS);
  always_comb begin
    s1_d.a_hi = min_i[LOA_WIDTH-1:SB];
    s1_d.b_hi = sub_i[LOA_WIDTH-1:SB];
    s1_d.diff_lo = (mid[SB-1:0] & ~lo_mask) | ((min_i[SB-1:0] | ~sub_i[SB-1:0]) & lo_mask);
    s1_d.borrow = mid[SB];
  end
`ifdef LOA_SUB_ERRSTAT_EN
  assign s1_in = {s1_d, min_i, sub_i};
`else
  assign s1_in = s1_d;
`endif
  assign s1_q = s1_data_q[S1W-1 -: $bits(loa_s1_t)];
  loa_pipe_reg #(.W(S1W)) u_s1 (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .data_i     (s1_in),
    .valid_o    (s1_valid),
    .data_o     (s1_data_q),
    .out_ready_i(s2_ready)
  );
  assign hi = {1'b0, s1_q.a_hi} - {1'b0, s1_q.b_hi} - (HW+1)'(s1_q.borrow);
  assign res_d = {hi[HW], hi[HW-1:0], s1_q.diff_lo};
`ifdef LOA_SUB_ERRSTAT_EN
  assign s2_in = {res_d != loa_exact(s1_data_q[2*LOA_WIDTH-1:LOA_WIDTH], s1_data_q[LOA_WIDTH-1:0]), res_d};
`else
  assign s2_in = res_d;
`endif
  loa_pipe_reg #(.W(S2W)) u_s2 (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (s1_valid),
    .in_ready_o (s2_ready),
    .data_i     (s2_in),
    .valid_o    (out_valid_o),
    .data_o     (s2_data_q),
    .out_ready_i(out_ready_i)
  );
  assign result_o = s2_data_q[LOA_WIDTH:0];
`ifdef LOA_SUB_ERRSTAT_EN
  logic [15:0] errcnt_q;
  logic [15:0] errcnt_d;
  always_comb begin
    errcnt_d = errclr_i ? 16'h0000
             : (out_valid_o & out_ready_i & s2_data_q[LOA_WIDTH+1] & (errcnt_q != 16'hFFFF)) ? errcnt_q + 16'd1
             : errcnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) errcnt_q <= 16'h0000;
    else errcnt_q <= errcnt_d;
  end
  assign errcnt_o = errcnt_q;
`endif
endmodule

// File: tb/tb_loa_sub_pipe.sv
// tb_loa_sub_pipe: directed checks of the approximate subtractor pipeline (LOWER_BITS=8).
// Error-statistics checks are included when LOA_SUB_ERRSTAT_EN is defined.
module tb_loa_sub_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:0] result;
  logic        out_valid;
  logic        out_ready = 1'b1;
`ifdef LOA_SUB_ERRSTAT_EN
  logic [15:0] errcnt;
  logic        errclr = 1'b0;
`endif
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  loa_sub_pipe #(.LOWER_BITS(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .min_i      (a),
    .sub_i      (b),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .result_o   (result),
`ifdef LOA_SUB_ERRSTAT_EN
    .errcnt_o   (errcnt),
    .errclr_i   (errclr),
`endif
    .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  function automatic logic [32:0] ref_loa(input logic [31:0] x, input logic [31:0] y);
    logic [7:0]  lo;
    logic [24:0] up;
    logic        bi;
    for (int i = 0; i < 8; i++) lo[i] = x[i] | ~y[i];
    bi = ~x[7] & y[7];
    up = {1'b0, x[31:8]} - {1'b0, y[31:8]} - 25'(bi);
    return {up, lo};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [32:0] exp);
    a = x;
    b = y;
    in_valid = 1'b1;
    #1 chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_res"}, 64'(result), 64'(exp));
    tick();
  endtask

  logic [31:0] sa [10];
  logic [31:0] sb [10];
  logic [32:0] held;
  logic        stalled;
  int          wr;
  int          rd;
  logic        ih;
  logic        oh;
  logic [3:0]  rpat;

  initial begin
    #3;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1 chk("rst_ready", 64'(in_ready), 64'd1);

    send("v036", 32'h00000100, 32'h00000001, 33'h0_000001FE);
`ifdef LOA_SUB_ERRSTAT_EN
    chk("v036_errcnt", 64'(errcnt), 64'd1);
`endif
    send("v037", 32'h00000010, 32'h00000080, 33'h1_FFFFFF7F);
    send("v038", 32'hFFFFFFFF, 32'h00000000, 33'h0_FFFFFFFF);
`ifdef LOA_SUB_ERRSTAT_EN
    chk("v038_errcnt", 64'(errcnt), 64'd2);
`endif
    send("wrap_hi", 32'h00000100, 32'h00000200, 33'h1_FFFFFFFF);
    send("wrap_lo", 32'h00000000, 32'h00000001, 33'h0_000000FE);
    send("mixed", 32'h12345678, 32'h11111111, ref_loa(32'h12345678, 32'h11111111));

    sa = '{32'h00000100, 32'h00000010, 32'hFFFFFFFF, 32'h80000000, 32'h000FFF00,
           32'h00100000, 32'hDEADBEEF, 32'h00000000, 32'h7FFFFFFF, 32'h0ABCDEF0};
    sb = '{32'h00000001, 32'h00000080, 32'h00000000, 32'h00000001, 32'h00100080,
           32'h00000080, 32'hCAFEBABE, 32'hFFFFFFFF, 32'h80000000, 32'h0ABCDEF0};
    rpat = 4'b1001;
    wr = 0;
    rd = 0;
    stalled = 1'b0;
    for (int c = 0; c < 200 && rd < 10; c++) begin
      out_ready = rpat[c % 4];
      in_valid = (wr < 10);
      a = sa[wr < 10 ? wr : 0];
      b = sb[wr < 10 ? wr : 0];
      #1;
      if (stalled) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_hold", 64'(result), 64'(held));
      end
      chk("stream_ready", 64'(in_ready), 64'(!((wr - rd) == 2 && !out_ready)));
      ih = in_valid & in_ready;
      oh = out_valid & out_ready;
      if (oh) begin
        chk($sformatf("stream_res%0d", rd), 64'(result), 64'(ref_loa(sa[rd], sb[rd])));
        rd++;
      end
      stalled = out_valid & ~out_ready;
      held = result;
      @(posedge clk);
      if (ih) wr++;
      #1;
    end
    in_valid = 1'b0;
    chk("stream_count", 64'(rd), 64'd10);

    out_ready = 1'b0;
    a = 32'h00000100;
    b = 32'h00000001;
    in_valid = 1'b1;
    tick();
    a = 32'h00000200;
    tick();
    in_valid = 1'b0;
    chk("flight_valid", 64'(out_valid), 64'd1);
    chk("flight_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("arst_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("arst_nostale", 64'(out_valid), 64'd0);
    end

`ifdef LOA_SUB_ERRSTAT_EN
    errclr = 1'b1;
    tick();
    errclr = 1'b0;
    chk("errclr_idle", 64'(errcnt), 64'd0);
    a = 32'h00000100;
    b = 32'h00000001;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 32'h10001 + 2; c++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("errcnt_sat", 64'(errcnt), 64'hFFFF);
    in_valid = 1'b1;
    tick();
    tick();
    errclr = 1'b1;
    #1 chk("errclr_hs", 64'(out_valid & out_ready), 64'd1);
    tick();
    errclr = 1'b0;
    in_valid = 1'b0;
    chk("errclr_prio", 64'(errcnt), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/loa_sub_pipe.md
LOA_SUB_PIPE -- requirements
Module: loa_sub_pipe

Interface
REQ-001 Parameter LOWER_BITS, default 8: number of approximated low bits (legal range 1..16).
REQ-002 clk_i input 1: single clock; all state changes on its rising edge.
REQ-003 rst_ni input 1: reset, asynchronous, active-low.
REQ-004 min_i input 32: minuend a.
REQ-005 sub_i input 32: subtrahend b.
REQ-006 in_valid_i input 1: operand pair valid.
REQ-007 in_ready_o output 1: block accepts the operand pair this cycle.
REQ-008 result_o output 33: {borrow_out, diff[31:0]}.
REQ-009 out_valid_o output 1: result_o valid.
REQ-010 out_ready_i input 1: consumer accepts result_o.
REQ-011 errcnt_o output 16, and errclr_i input 1: present only with LOA_SUB_ERRSTAT_EN (see Configuration).

Function
REQ-012 Lower part: diff[i] SHALL be a[i] | ~b[i] for i < LOWER_BITS.
REQ-013 Borrow into bit LOWER_BITS SHALL be ~a[LOWER_BITS-1] & b[LOWER_BITS-1].
REQ-014 Upper part: diff[31:LOWER_BITS] SHALL be exact a[31:L] - b[31:L] - borrow_in; result_o[32] SHALL be the borrow-out of bit 31.
REQ-015 Stage 1 SHALL compute the lower part and the exact bits [19:L], and register the stage-1 borrow.
REQ-016 Stage 2 SHALL compute bits [31:20] from the stage-1 borrow.
REQ-017 Latency SHALL be 2 cycles from an input handshake to out_valid_o, with no stalls.
REQ-018 Throughput SHALL be 1 result per cycle while out_ready_i=1.
REQ-019 Input handshake SHALL occur when in_valid_i & in_ready_o.
REQ-020 Output handshake SHALL occur when out_valid_o & out_ready_i.
REQ-021 Each stage SHALL load when it is empty or its downstream stage advances this cycle.
REQ-022 in_ready_o = ~s1_valid | stage-1 advance; it SHALL be combinational from out_ready_i only, never from in_valid_i.
REQ-023 With out_valid_o=1 and out_ready_i=0, result_o SHALL hold stable, and no accepted operand SHALL be lost or duplicated.
REQ-024 A simultaneous input and output handshake with both stages full SHALL shift the pipeline in one cycle.
REQ-025 Wrap-around: a < b SHALL yield a two's-complement diff and borrow_out=1; there are no saturation modes.

Reset
REQ-026 Asserting rst_ni SHALL immediately clear s1_valid and s2_valid, and set out_valid_o=0 and result_o=0.
REQ-027 Reset mid-operation SHALL discard all in-flight operands; no result for them SHALL appear after reset.
REQ-028 After rst_ni deasserts, in_ready_o SHALL be 1.
REQ-029 With LOA_SUB_ERRSTAT_EN, errcnt_o SHALL reset to 0.

Configuration
REQ-030 Macro LOA_SUB_ERRSTAT_EN defined: the block SHALL compute the exact a-b in parallel at stage 2.
REQ-031 With the macro, errcnt_o SHALL increment, saturating at 0xFFFF, on each output handshake whose 33-bit result differs from the exact value.
REQ-032 With the macro, errclr_i SHALL synchronously set errcnt_o to 0 and take priority over a same-cycle increment.
REQ-033 Macro undefined: errcnt_o, errclr_i and the exact-path logic SHALL be absent; the datapath is unchanged.

Structure
REQ-034 Shared package loa_pkg SHALL hold LOA_WIDTH=32, LOA_LOWER_BITS_DEFAULT=8, LOA_SPLIT_BIT=20, and typedef loa_result_t (33-bit).
REQ-035 A sub-module loa_pipe_reg SHALL implement one valid/ready pipeline stage: data register plus valid flag, async active-low reset; it is instantiated twice.

Verification
REQ-036 a=0x00000100, b=0x00000001 -> result_o=0x0_000001FE; with macro, errcnt_o=1.
REQ-037 a=0x00000010, b=0x00000080 -> result_o=0x1_FFFFFF7F (borrow_out=1).
REQ-038 a=0xFFFFFFFF, b=0x00000000 -> result_o=0x0_FFFFFFFF; errcnt_o unchanged.
REQ-039 Back-to-back stream of 10 pairs, out_ready_i toggling 1,0,0,1 repeating -> 10 results in order, result_o stable while stalled, in_ready_o=0 when both stages are full.
REQ-040 Two pairs in flight, rst_ni pulsed low for 1 cycle -> out_valid_o=0 immediately, no stale result after release, in_ready_o=1.
REQ-041 With macro: 0x10001 mismatching pairs -> errcnt_o=0xFFFF; errclr_i asserted during a mismatching handshake -> errcnt_o=0.
